// File: rtl/phase_diff_disc.sv
// rtl/phase_diff_disc.sv - wrapped phase-difference FM discriminator with sliding-window average
// Optional macro PHASE_DIFF_FILL_GATE_EN holds off output until the averaging window is full.
module phase_diff_disc #(
  parameter int PAR_PHASE_WIDTH     = 16,
  parameter int PAR_PHASE_INT_WIDTH = 9,
  parameter int PAR_AVG_LOG2        = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       s_axis_tvalid,
  input  logic [PAR_PHASE_WIDTH-1:0] s_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic [PAR_PHASE_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tuser
);

  localparam int W      = PAR_PHASE_WIDTH;
  localparam int FRAC   = PAR_PHASE_WIDTH - PAR_PHASE_INT_WIDTH;
  localparam int WIN    = 1 << PAR_AVG_LOG2;
  localparam int PTR_W  = (PAR_AVG_LOG2 > 0) ? PAR_AVG_LOG2 : 1;
  localparam int ACC_W  = PAR_PHASE_WIDTH + PAR_AVG_LOG2;
  localparam int FILL_W = PAR_AVG_LOG2 + 1;
  localparam int PI_Q   = $rtoi(3.141592653589793 * real'(1 << FRAC) + 0.5);

  localparam logic signed [W:0]       PI_S     = (W+1)'(PI_Q);
  localparam logic signed [W:0]       NEG_PI_S = (W+1)'(-PI_Q);
  localparam logic signed [W:0]       TWO_PI_S = (W+1)'(2 * PI_Q);
  localparam logic [PTR_W-1:0]        PTR_MASK = PTR_W'(WIN - 1);
  localparam logic [FILL_W-1:0]       FILL_MAX = FILL_W'(WIN);

  logic                   have_prev;
  logic signed [W-1:0]    prev_phase;
  logic                   v0;
  logic signed [W:0]      raw;
  logic                   v1;
  logic signed [W-1:0]    diff;
  logic signed [W-1:0]    win_buf [WIN];
  logic [PTR_W-1:0]       wptr;
  logic signed [ACC_W-1:0] acc;
  logic [FILL_W-1:0]      fill;

  logic signed [W:0]       in_ext;
  logic signed [W:0]       prev_ext;
  logic signed [W:0]       raw_next;
  logic signed [W-1:0]     wrapped;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [W-1:0]     avg;
  logic [FILL_W-1:0]       fill_next;
  logic                    out_ok;

  always_comb begin
    in_ext   = {s_axis_tdata[W-1], s_axis_tdata};
    prev_ext = {prev_phase[W-1], prev_phase};
    raw_next = in_ext - prev_ext;

    // Fold the difference back into (-pi, pi] so a wrap of the atan output reads as a small step.
    if (raw > PI_S) begin
      wrapped = W'(raw - TWO_PI_S);
    end else if (raw <= NEG_PI_S) begin
      wrapped = W'(raw + TWO_PI_S);
    end else begin
      wrapped = W'(raw);
    end

    acc_next  = acc + ACC_W'(diff) - ACC_W'(win_buf[wptr]);
    avg       = W'(acc_next >>> PAR_AVG_LOG2);
    fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
`ifdef PHASE_DIFF_FILL_GATE_EN
    out_ok    = (fill_next == FILL_MAX);
`else
    out_ok    = 1'b1;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      // A clear that coincides with a sample keeps it as the new reference phase.
      have_prev     <= i_clear && !i_rst && s_axis_tvalid;
      prev_phase    <= (i_clear && !i_rst && s_axis_tvalid) ? s_axis_tdata : '0;
      v0            <= 1'b0;
      raw           <= '0;
      v1            <= 1'b0;
      diff          <= '0;
      for (int i = 0; i < WIN; i++) begin
        win_buf[i] <= '0;
      end
      wptr          <= '0;
      acc           <= '0;
      fill          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
    end else begin
      v0 <= 1'b0;
      if (s_axis_tvalid) begin
        prev_phase <= s_axis_tdata;
        have_prev  <= 1'b1;
        if (have_prev) begin
          raw <= raw_next;
          v0  <= 1'b1;
        end
      end

      v1 <= v0;
      if (v0) begin
        diff <= wrapped;
      end

      m_axis_tvalid <= 1'b0;
      if (v1) begin
        acc           <= acc_next;
        win_buf[wptr] <= diff;
        wptr          <= (wptr + 1'b1) & PTR_MASK;
        fill          <= fill_next;
        m_axis_tvalid <= out_ok;
        m_axis_tdata  <= avg;
        m_axis_tuser  <= ~avg[W-1];
      end
    end
  end

endmodule

// File: tb/tb_phase_diff_disc.sv
// tb/tb_phase_diff_disc.sv - directed bench for phase_diff_disc, window 4 and window 1 instances
module tb_phase_diff_disc;

`ifdef PHASE_DIFF_FILL_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, tvalid;
  logic [15:0] tdata;
  logic        v0, u0, v1, u1;
  logic [15:0] d0, d1;

  phase_diff_disc #(.PAR_PHASE_WIDTH(16), .PAR_PHASE_INT_WIDTH(9), .PAR_AVG_LOG2(2)) dut_l2 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .m_axis_tvalid(v0), .m_axis_tdata(d0), .m_axis_tuser(u0));

  phase_diff_disc #(.PAR_PHASE_WIDTH(16), .PAR_PHASE_INT_WIDTH(9), .PAR_AVG_LOG2(0)) dut_l0 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .m_axis_tvalid(v1), .m_axis_tdata(d1), .m_axis_tuser(u1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   q0[$], q1[$], c0[$], c1[$], drv[$];
  logic qu0[$], qu1[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    if (v0) begin q0.push_back(int'($signed(d0))); qu0.push_back(u0); c0.push_back(cyc); end
    if (v1) begin q1.push_back(int'($signed(d1))); qu1.push_back(u1); c1.push_back(cyc); end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input int p);
    drv.push_back(cyc);
    tvalid = 1'b1;
    tdata  = 16'(p);
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; tvalid = 1'b0; tdata = '0;
    idle(2);
    rst = 1'b0;
    q0.delete(); q1.delete(); c0.delete(); c1.delete(); qu0.delete(); qu1.delete(); drv.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; tvalid = 1'b1; tdata = 16'd123;
    idle(3);
    n_checks++;
    if ({v0, d0, u0} !== 18'd0) begin
      n_fail++; $display("FAIL reset_l2: got v=%0b d=%0d u=%0b, expected all 0", v0, d0, u0);
    end
    n_checks++;
    if ({v1, d1, u1} !== 18'd0) begin
      n_fail++; $display("FAIL reset_l0: got v=%0b d=%0d u=%0b, expected all 0", v1, d1, u1);
    end
    do_reset();
  endtask

  task automatic test_ramp(input bit gapped);
    int e0[$], e1[$];
    int got, lat_idx, lat;
    logic gu;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      put(100 * k);
      if (gapped) idle(16);
    end
    idle(6);
    if (GATE) e0 = '{100}; else e0 = '{25, 50, 75, 100};
    e1 = '{100, 100, 100, 100};
    lat_idx = GATE ? 4 : 1;
    n_checks++;
    if (q0.size() != e0.size() || q1.size() != e1.size()) begin
      n_fail++; $display("FAIL ramp%0d_count: got %0d/%0d outputs, expected %0d/%0d", gapped, q0.size(), q1.size(), e0.size(), e1.size());
    end
    for (int i = 0; i < e0.size(); i++) begin
      got = (i < q0.size()) ? q0[i] : 99999; gu = (i < qu0.size()) ? qu0[i] : 1'bx;
      n_checks++;
      if (got !== e0[i] || gu !== (e0[i] >= 0)) begin
        n_fail++; $display("FAIL ramp%0d_l2[%0d]: got %0d/%0b, expected %0d/%0b", gapped, i, got, gu, e0[i], e0[i] >= 0);
      end
    end
    for (int i = 0; i < e1.size(); i++) begin
      got = (i < q1.size()) ? q1[i] : 99999; gu = (i < qu1.size()) ? qu1[i] : 1'bx;
      n_checks++;
      if (got !== e1[i] || gu !== 1'b1) begin
        n_fail++; $display("FAIL ramp%0d_l0[%0d]: got %0d/%0b, expected %0d/1", gapped, i, got, gu, e1[i]);
      end
    end
    lat = (c0.size() > 0) ? c0[0] - drv[lat_idx] : -1;
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL ramp%0d_latency_l2: got %0d cycles, expected 3", gapped, lat);
    end
    lat = (c1.size() > 0) ? c1[0] - drv[1] : -1;
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL ramp%0d_latency_l0: got %0d cycles, expected 3", gapped, lat);
    end
  endtask

  task automatic test_wrap();
    int e1[$];
    int got;
    logic gu;
    do_reset();
    put(390); put(-390); put(390);
    idle(6);
    e1 = '{24, -24};
    n_checks++;
    if (q1.size() != 2) begin
      n_fail++; $display("FAIL wrap_count: got %0d outputs, expected 2", q1.size());
    end
    for (int i = 0; i < e1.size(); i++) begin
      got = (i < q1.size()) ? q1[i] : 99999; gu = (i < qu1.size()) ? qu1[i] : 1'bx;
      n_checks++;
      if (got !== e1[i] || gu !== (e1[i] >= 0)) begin
        n_fail++; $display("FAIL wrap[%0d]: got %0d/%0b, expected %0d/%0b", i, got, gu, e1[i], e1[i] >= 0);
      end
    end
  endtask

  task automatic test_boundary();
    int e0[$];
    int got;
    do_reset();
    put(0); put(402); put(0); put(-402); put(0);
    idle(6);
    if (GATE) e0 = '{402}; else e0 = '{100, 201, 301, 402};
    n_checks++;
    if (q1.size() != 4 || q0.size() != e0.size()) begin
      n_fail++; $display("FAIL boundary_count: got %0d/%0d outputs, expected %0d/4", q0.size(), q1.size(), e0.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < q1.size()) ? q1[i] : 99999;
      n_checks++;
      if (got !== 402) begin
        n_fail++; $display("FAIL boundary_l0[%0d]: got %0d, expected 402", i, got);
      end
    end
    for (int i = 0; i < e0.size(); i++) begin
      got = (i < q0.size()) ? q0[i] : 99999;
      n_checks++;
      if (got !== e0[i]) begin
        n_fail++; $display("FAIL boundary_l2[%0d]: got %0d, expected %0d", i, got, e0[i]);
      end
    end
  endtask

  task automatic test_negative();
    int e0[$];
    int got;
    logic gu;
    do_reset();
    for (int k = 0; k < 5; k++) put(-k);
    idle(6);
    if (GATE) e0 = '{-1}; else e0 = '{-1, -1, -1, -1};
    n_checks++;
    if (q0.size() != e0.size() || q1.size() != 4) begin
      n_fail++; $display("FAIL negative_count: got %0d/%0d outputs, expected %0d/4", q0.size(), q1.size(), e0.size());
    end
    for (int i = 0; i < e0.size(); i++) begin
      got = (i < q0.size()) ? q0[i] : 99999; gu = (i < qu0.size()) ? qu0[i] : 1'bx;
      n_checks++;
      if (got !== -1 || gu !== 1'b0) begin
        n_fail++; $display("FAIL negative_l2[%0d]: got %0d/%0b, expected -1/0", i, got, gu);
      end
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < q1.size()) ? q1[i] : 99999; gu = (i < qu1.size()) ? qu1[i] : 1'bx;
      n_checks++;
      if (got !== -1 || gu !== 1'b0) begin
        n_fail++; $display("FAIL negative_l0[%0d]: got %0d/%0b, expected -1/0", i, got, gu);
      end
    end
  endtask

  task automatic test_clear();
    int e0[$], e1[$];
    int got;
    do_reset();
    put(0); put(40);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    idle(5);
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++; $display("FAIL clear_drop: got %0d/%0d outputs, expected 0/0", q0.size(), q1.size());
    end
    put(0); put(40);
    idle(6);
    clr = 1'b1; tvalid = 1'b1; tdata = 16'd100;
    @(negedge clk);
    clr = 1'b0; tvalid = 1'b0;
    put(140);
    idle(6);
    if (GATE) e0 = {}; else e0 = '{10, 10};
    e1 = '{40, 40};
    n_checks++;
    if (q0.size() != e0.size() || q1.size() != e1.size()) begin
      n_fail++; $display("FAIL clear_count: got %0d/%0d outputs, expected %0d/%0d", q0.size(), q1.size(), e0.size(), e1.size());
    end
    for (int i = 0; i < e0.size(); i++) begin
      got = (i < q0.size()) ? q0[i] : 99999;
      n_checks++;
      if (got !== e0[i]) begin
        n_fail++; $display("FAIL clear_l2[%0d]: got %0d, expected %0d", i, got, e0[i]);
      end
    end
    for (int i = 0; i < e1.size(); i++) begin
      got = (i < q1.size()) ? q1[i] : 99999;
      n_checks++;
      if (got !== e1[i]) begin
        n_fail++; $display("FAIL clear_l0[%0d]: got %0d, expected %0d", i, got, e1[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; tvalid = 1'b0; tdata = '0;
    @(negedge clk);
    test_reset();
    test_ramp(1'b0);
    test_wrap();
    test_boundary();
    test_negative();
    test_clear();
    test_ramp(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
